i2s_leftjustified_rx: RTL
=========================

I2S_LEFTJUSTIFIED_RX -- requirements
Module: i2s_leftjustified_rx

Interface
REQ-001 SHALL have port MCLK_i, input, 1, system clock at 24.576 MHz; all logic on its rising edge.
REQ-002 SHALL have port nRST_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port SCLK_i, input, 1, serial bit clock, asynchronous to MCLK_i, at most MCLK_i/8, idle high.
REQ-004 SHALL have port LRCLK_i, input, 1, word select: high = left, low = right.
REQ-005 SHALL have port SDATA_i, input, 1, serial data, MSB first, stable at SCLK_i rising edge.
REQ-006 SHALL have port PDATA_LEFT_o, output, 24, last complete left sample.
REQ-007 SHALL have port PDATA_RIGHT_o, output, 24, last complete right sample.
REQ-008 SHALL have port PDATA_VALID_o, output, 1, one-MCLK pulse when both outputs update.
REQ-009 SHALL have port SYNC_o, output, 1, high while locked to LRCLK framing.
REQ-010 SHALL have port FRAME_ERR_o, output, 1, one-MCLK pulse on framing violation.

Function
REQ-011 SHALL pass SCLK_i, LRCLK_i and SDATA_i through two-flop synchronizers; edge detection SHALL compare the 2nd and 3rd stages.
REQ-012 SHALL treat a synchronized SCLK rising edge as a bit strobe: sample SDATA and LRCLK on that cycle.
REQ-013 SHALL detect a word boundary at a strobe whose sampled LRCLK differs from the previous strobe's LRCLK; that strobe's bit SHALL be bit 31 (MSB) of the new word.
REQ-014 SHALL keep a 6-bit bit counter: 1 at a boundary strobe, +1 on each later strobe, saturating at 63.
REQ-015 SHALL shift the first 24 bits of each word MSB-first into a 24-bit shift register; bits 25..N SHALL be ignored.
REQ-016 SHALL use states HUNT and LOCK: HUNT -> LOCK at the first boundary strobe; LOCK -> HUNT on a framing error (REQ-025) or on no strobe for 1024 MCLK cycles.
REQ-017 SHALL copy the shift register into a left or right holding register, chosen by the word's LRCLK, at the strobe that samples bit 24 of that word, in LOCK only.
REQ-018 SHALL discard any word whose count is below 24 at the next boundary. No holding register SHALL be written for it.
REQ-019 SHALL, once a right word is captured and a left word was captured immediately before it, update PDATA_LEFT_o and PDATA_RIGHT_o and pulse PDATA_VALID_o. This SHALL happen in the MCLK cycle after that right-capture strobe.
REQ-020 SHALL never assert PDATA_VALID_o for a right word without a preceding left word, including the first right word after HUNT -> LOCK.
REQ-021 SHALL hold PDATA_LEFT_o/PDATA_RIGHT_o unchanged between valid pulses.
REQ-022 SHALL assert SYNC_o after two consecutive valid pulses in LOCK, and deassert it in the cycle the state returns to HUNT.
REQ-023 SHALL handle a boundary strobe that coincides with the 1024-cycle timeout expiry by taking the boundary; the timeout counter SHALL be cleared.

Reset
REQ-024 SHALL, while nRST_i is low, force:
- state HUNT
- synchronizer stages: SCLK 1, LRCLK 0, SDATA 0
- counters 0
- shift and holding registers 0
- PDATA_LEFT_o = PDATA_RIGHT_o = 0
- PDATA_VALID_o = SYNC_o = FRAME_ERR_o = 0
Reset asserted mid-word SHALL discard that word; after release, capture SHALL start only at the next boundary.

Configuration
REQ-025 SHALL compile strict framing check when I2S_RX_FRAMECHK_EN is defined:
- a boundary with bit count not equal to 32 SHALL pulse FRAME_ERR_o for one cycle
- the state SHALL return to HUNT
- the word being completed SHALL be discarded
REQ-026 SHALL, without I2S_RX_FRAMECHK_EN, tie FRAME_ERR_o to 0 and accept any count of 24 or more.

Verification
REQ-027 Reset is released. The bench drives frames with SCLK = MCLK/8, 32 bits per half, left 0x123456 and right 0xABCDEF, padded with 8 LSB copies. Required: first valid pulse with PDATA_LEFT_o = 0x123456 and PDATA_RIGHT_o = 0xABCDEF; SYNC_o high after the 2nd pulse.
REQ-028 The bench starts the stream mid-right-word. Required: no valid pulse until a full left word followed by a full right word; the first pulse carries that pair.
REQ-029 The bench stops SCLK for 1100 MCLK cycles while locked. Required: SYNC_o falls about 1024 cycles after the last strobe; outputs hold their last values.
REQ-030 With I2S_RX_FRAMECHK_EN, the bench sends one left half of 30 bits. Required: one FRAME_ERR_o pulse, SYNC_o low, no valid pulse for that frame. Without the macro: FRAME_ERR_o stays 0 and data is captured.
REQ-031 The bench sends a right half of only 20 bits. Required: the word is discarded and there is no valid pulse. With the macro, FRAME_ERR_o also pulses.
REQ-032 The bench pulses nRST_i low for 3 cycles mid-left-word. Required: all outputs 0 at once; correct capture resumes from the next complete left/right pair.

Source files
------------

// File: rtl/i2s_leftjustified_rx.sv
// Left-justified serial audio receiver: 24-bit left/right capture from up to 32-bit slots.
// Define I2S_RX_FRAMECHK_EN to compile the strict 32-bit framing check (FRAME_ERR_o).
module i2s_leftjustified_rx (
  input  logic        MCLK_i,
  input  logic        nRST_i,
  input  logic        SCLK_i,
  input  logic        LRCLK_i,
  input  logic        SDATA_i,
  output logic [23:0] PDATA_LEFT_o,
  output logic [23:0] PDATA_RIGHT_o,
  output logic        PDATA_VALID_o,
  output logic        SYNC_o,
  output logic        FRAME_ERR_o,
  output logic        STATE_DBG_o
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_q;
  logic [1:0]  lrclk_q, sdata_q;
  logic        prev_vld_q, prev_vld_d;
  logic        prev_lr_q, prev_lr_d;
  logic        word_lr_q, word_lr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] left_hold_q, left_hold_d;
  logic [23:0] out_left_q, out_left_d;
  logic [23:0] out_right_q, out_right_d;
  logic        left_pend_q, left_pend_d;
  logic [1:0]  pair_cnt_q, pair_cnt_d;
  logic        valid_q, valid_d;
  logic        sync_q, sync_d;
  logic        ferr_q, ferr_d;

  logic        strobe, lr_smp, bit_smp, boundary, capture, frame_bad;
  logic [23:0] cap_word;

  // Edge detect on stages 2/3; LRCLK and SDATA stage 2 is aligned with it.
  assign strobe   = sclk_q[1] & ~sclk_q[2];
  assign lr_smp   = lrclk_q[1];
  assign bit_smp  = sdata_q[1];
  // The first strobe after reset only records LRCLK, so a word cut by reset is never taken.
  assign boundary = strobe & prev_vld_q & (lr_smp != prev_lr_q);
  assign capture  = strobe & ~boundary & (bit_cnt_q == 6'd23) & (state_q == LOCK);
  assign cap_word = {shift_q[22:0], bit_smp};

`ifdef I2S_RX_FRAMECHK_EN
  assign frame_bad = boundary & (state_q == LOCK) & (bit_cnt_q != 6'd32);
`else
  assign frame_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    prev_vld_d  = prev_vld_q;
    prev_lr_d   = prev_lr_q;
    word_lr_d   = word_lr_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    left_pend_d = left_pend_q;
    pair_cnt_d  = pair_cnt_q;
    sync_d      = sync_q;
    valid_d     = 1'b0;
    ferr_d      = frame_bad;

    if (strobe) begin
      prev_vld_d = 1'b1;
      prev_lr_d  = lr_smp;
      to_cnt_d   = '0;
      if (boundary) begin
        bit_cnt_d = 6'd1;
        word_lr_d = lr_smp;
      end else if (bit_cnt_q != 6'd63) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end
      if (bit_cnt_d <= 6'd24) shift_d = cap_word;
    end else if (to_cnt_q != 10'd1023) begin
      to_cnt_d = to_cnt_q + 10'd1;
    end

    // A short word breaks the left/right pairing.
    if (boundary && (bit_cnt_q < 6'd24)) left_pend_d = 1'b0;

    // An unpaired right word has no consumer, so it goes straight to the output only when paired.
    if (capture) begin
      if (word_lr_q) begin
        left_hold_d = cap_word;
        left_pend_d = 1'b1;
      end else begin
        left_pend_d = 1'b0;
        if (left_pend_q) begin
          out_left_d  = left_hold_q;
          out_right_d = cap_word;
          valid_d     = 1'b1;
          if (pair_cnt_q != 2'd2) pair_cnt_d = pair_cnt_q + 2'd1;
          if (pair_cnt_q != 2'd0) sync_d = 1'b1;
        end
      end
    end

    case (state_q)
      HUNT:    if (boundary) state_d = LOCK;
      LOCK:    if (frame_bad || (!strobe && (to_cnt_q == 10'd1023))) state_d = HUNT;
      default: state_d = HUNT;
    endcase

    if (state_d == HUNT) begin
      left_pend_d = 1'b0;
      pair_cnt_d  = '0;
      sync_d      = 1'b0;
    end
  end

  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_q     <= HUNT;
      sclk_q      <= 3'b111;
      lrclk_q     <= '0;
      sdata_q     <= '0;
      prev_vld_q  <= 1'b0;
      prev_lr_q   <= 1'b0;
      word_lr_q   <= 1'b0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      left_pend_q <= 1'b0;
      pair_cnt_q  <= '0;
      valid_q     <= 1'b0;
      sync_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= {sclk_q[1:0], SCLK_i};
      lrclk_q     <= {lrclk_q[0], LRCLK_i};
      sdata_q     <= {sdata_q[0], SDATA_i};
      prev_vld_q  <= prev_vld_d;
      prev_lr_q   <= prev_lr_d;
      word_lr_q   <= word_lr_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      left_pend_q <= left_pend_d;
      pair_cnt_q  <= pair_cnt_d;
      valid_q     <= valid_d;
      sync_q      <= sync_d;
      ferr_q      <= ferr_d;
    end
  end

  assign PDATA_LEFT_o  = out_left_q;
  assign PDATA_RIGHT_o = out_right_q;
  assign PDATA_VALID_o = valid_q;
  assign SYNC_o        = sync_q;
  assign FRAME_ERR_o   = ferr_q;
  assign STATE_DBG_o   = state_q;

endmodule
